multicycle_seq: RTL

//  Multi-cycle sequencer for the RV32I core. It shares one memory port between instruction

---
 rtl/multicycle_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port; gates decoder RF/DRAM writes.
// Strobes are combinational from state/op/ack; a memory request is held until acked or the timeout forces ERR.
module multicycle_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic [6:0]       op_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_sel_o,
    output logic             mem_we_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             rf_we_en_o,
    output logic [2:0]       stage_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic              r_is_store;
    logic              w_commit;
    logic              w_req;
    logic              w_wait_last;

    assign w_wait_last = (r_wait_cnt == WC_W'(TIMEOUT - 1));

    always_comb begin
        w_next     = r_state;
        w_commit   = 1'b0;
        w_req      = 1'b0;
        mem_sel_o  = 1'b0;
        mem_we_o   = 1'b0;
        ir_we_o    = 1'b0;
        rf_we_en_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run_i) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ack_i) begin
                    ir_we_o = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_wait_last) begin
                    w_next = S_ERR;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (op_i)
                    OP_LOAD, OP_STORE:                          w_next = S_MEM;
                    OP_BRANCH:                                  w_commit = 1'b1;
                    OP_ALU, OP_ALUI, OP_LUI, OP_JAL, OP_JALR:  w_next = S_WB;
                    default:                                    w_next = S_ERR;
                endcase
            end
            S_MEM: begin
                w_req     = 1'b1;
                mem_sel_o = 1'b1;
                mem_we_o  = r_is_store;
                if (mem_ack_i) begin
                    if (r_is_store) w_commit = 1'b1;
                    else            w_next   = S_WB;
                end else if (w_wait_last) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                rf_we_en_o = 1'b1;
                w_commit   = 1'b1;
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_ERR;
        endcase
        if (w_commit) w_next = run_i ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_instr_cnt <= '0;
            r_is_store  <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counter only advances while a request is still outstanding in the same state.
            if (w_req && !mem_ack_i && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;
            if (r_state == S_EXEC)
                r_is_store <= (op_i == OP_STORE);
            if (w_commit && (r_instr_cnt != {CNT_W{1'b1}}))
                r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign mem_req_o   = w_req;
    assign pc_we_o     = w_commit;
    assign stage_o     = r_state;
    assign busy_o      = (r_state != S_IDLE) && (r_state != S_ERR);
    assign err_o       = (r_state == S_ERR);
    assign instr_cnt_o = r_instr_cnt;

endmodule
